// File: rtl/reset_seq_pkg.sv
// Shared types for the multi-channel reset sequencer: command opcodes,
// FSM states and the counter "keep current value" encoding.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    TOGGLE    = 2'd0,
    ASSERT    = 2'd1,
    DEASSERT  = 2'd2,
    CONFIGURE = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    POR       = 3'd0,
    IDLE      = 3'd1,
    WAIT_IDLE = 3'd2,
    ACTIVE    = 3'd3,
    HELD      = 3'd4,
    RELEASE   = 3'd5
  } state_e;

  // All-ones of the given width; a command count equal to this keeps the
  // currently programmed value.
  function automatic logic [31:0] cnt_keep(input int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
  endfunction

endpackage

// File: rtl/reset_seq_release.sv
// Release scheduler for the reset sequencer. A start pulse releases the
// latched channel mask; with RESET_SEQ_STAGGER_EN defined, channels are
// released in ascending index order, one every STAGGER_CYCLES cycles,
// otherwise all of them on the start edge. o_done is high when no release
// is outstanding.
module reset_seq_release #(
  parameter int NUM_CHANNELS = 4
`ifdef RESET_SEQ_STAGGER_EN
  ,
  parameter int CNT_WIDTH      = 16,
  parameter int STAGGER_CYCLES = 2
`endif
) (
`ifdef RESET_SEQ_STAGGER_EN
  input  logic                    i_clock,
  input  logic                    i_reset,
`endif
  input  logic                    i_start,
  input  logic [NUM_CHANNELS-1:0] i_mask,
  output logic [NUM_CHANNELS-1:0] o_release,
  output logic                    o_done
);

`ifdef RESET_SEQ_STAGGER_EN
  localparam logic [NUM_CHANNELS-1:0] CH_ONE  = NUM_CHANNELS'(1);
  localparam logic [CNT_WIDTH-1:0]    CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]    RELOAD  =
    (STAGGER_CYCLES == 0) ? '0 : CNT_WIDTH'(STAGGER_CYCLES - 1);

  logic [NUM_CHANNELS-1:0] r_pend;
  logic [CNT_WIDTH-1:0]    r_stg;
  logic [NUM_CHANNELS-1:0] w_src;
  logic [NUM_CHANNELS-1:0] w_lsb;
  logic                    w_fire;

  // Pick the next channel(s) to release: the first one on start, later ones
  // when the stagger gap has elapsed.
  always_comb begin
    w_src     = i_start ? i_mask : r_pend;
    w_fire    = i_start || ((r_pend != '0) && (r_stg == '0));
    w_lsb     = w_src & (~w_src + CH_ONE);
    o_release = '0;
    if (w_fire) o_release = (STAGGER_CYCLES == 0) ? w_src : w_lsb;
  end

  // Track channels still waiting for release and the gap down-counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_pend <= '0;
      r_stg  <= '0;
    end else if (w_fire) begin
      r_pend <= w_src & ~o_release;
      r_stg  <= RELOAD;
    end else if (r_stg != '0) begin
      r_stg <= r_stg - CNT_ONE;
    end
  end

  assign o_done = (r_pend == '0);
`else
  assign o_release = i_start ? i_mask : '0;
  assign o_done    = 1'b1;
`endif

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset generator: power-on pulse, commanded pulses with
// programmable idle/active lengths, manual hold/release, masked staggered
// release and per-channel assert/deassert events. Staggered release is
// built only when RESET_SEQ_STAGGER_EN is defined.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int                      NUM_CHANNELS          = 4,
  parameter int                      CNT_WIDTH             = 16,
  parameter logic [NUM_CHANNELS-1:0] RESET_POLARITY        = '1,
  parameter int                      DEFAULT_IDLE_CYCLES   = 0,
  parameter int                      DEFAULT_ACTIVE_CYCLES = 10,
  parameter int                      STAGGER_CYCLES        = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [NUM_CHANNELS-1:0] cmd_mask,
  input  logic [CNT_WIDTH-1:0]    cmd_idle,
  input  logic [CNT_WIDTH-1:0]    cmd_active,
  output logic                    cmd_err,
  output logic                    busy,
  output logic [NUM_CHANNELS-1:0] rst_out,
  output logic [NUM_CHANNELS-1:0] rst_active,
  output logic [NUM_CHANNELS-1:0] evt_assert,
  output logic [NUM_CHANNELS-1:0] evt_deassert
);

  localparam logic [CNT_WIDTH-1:0] KEEP       = CNT_WIDTH'(cnt_keep(CNT_WIDTH));
  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] DEF_IDLE   = CNT_WIDTH'(DEFAULT_IDLE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] DEF_ACTIVE = CNT_WIDTH'(DEFAULT_ACTIVE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] POR_CNT    =
    (DEFAULT_ACTIVE_CYCLES == 0) ? '0 : CNT_WIDTH'(DEFAULT_ACTIVE_CYCLES - 1);

  state_e                  r_state;
  logic [CNT_WIDTH-1:0]    r_idle;
  logic [CNT_WIDTH-1:0]    r_active;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [NUM_CHANNELS-1:0] r_mask;
  logic                    r_kick;   // DEASSERT seen: start release next edge
  logic                    r_rej;    // accepted command rejected this edge
  logic                    r_err;
  logic                    r_ready;
  logic                    r_busy;
  logic [NUM_CHANNELS-1:0] r_act;
  logic [NUM_CHANNELS-1:0] r_rst_out;
  logic [NUM_CHANNELS-1:0] r_evt_a;
  logic [NUM_CHANNELS-1:0] r_evt_d;

  cmd_op_e                 w_op;
  logic                    w_accept;
  logic [CNT_WIDTH-1:0]    w_new_idle;
  logic [CNT_WIDTH-1:0]    w_new_active;
  logic [CNT_WIDTH-1:0]    w_act_m1;
  logic                    w_start;
  logic [NUM_CHANNELS-1:0] w_release;
  logic                    w_rel_done;
  logic [NUM_CHANNELS-1:0] w_act_next;

  assign w_op         = cmd_op_e'(cmd_op);
  assign w_accept     = cmd_valid && r_ready;
  assign w_new_idle   = (cmd_idle == KEEP) ? r_idle : cmd_idle;
  assign w_new_active = (cmd_active == KEEP) ? r_active : cmd_active;
  assign w_act_m1     = (r_active == '0) ? '0 : r_active - ONE;

  // The first release coincides with the end of a POR/ACTIVE count, or
  // follows one cycle after a DEASSERT from HELD.
  assign w_start = !reset &&
                   ((((r_state == POR) || (r_state == ACTIVE)) && (r_cnt == '0)) ||
                    ((r_state == RELEASE) && r_kick));

  reset_seq_release #(
`ifdef RESET_SEQ_STAGGER_EN
    .CNT_WIDTH      (CNT_WIDTH),
    .STAGGER_CYCLES (STAGGER_CYCLES),
`endif
    .NUM_CHANNELS   (NUM_CHANNELS)
  ) u_release (
`ifdef RESET_SEQ_STAGGER_EN
    .i_clock   (clock),
    .i_reset   (reset),
`endif
    .i_start   (w_start),
    .i_mask    (r_mask),
    .o_release (w_release),
    .o_done    (w_rel_done)
  );

  // Next channel activity: set masked channels on leaving WAIT_IDLE or while
  // HELD, clear whatever the release scheduler frees.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_act_next = r_act;
    if (reset) begin
      w_act_next = '1;
    end else begin
      if (((r_state == WAIT_IDLE) && (r_cnt == '0)) || (r_state == HELD))
        w_act_next = w_act_next | r_mask;
      w_act_next = w_act_next & ~w_release;
    end
  end

  // Sequencer FSM: command decode, counters, latched mask and handshake.
  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= POR;
      r_idle   <= DEF_IDLE;
      r_active <= DEF_ACTIVE;
      r_mask   <= '1;
      r_cnt    <= POR_CNT;
      r_kick   <= 1'b0;
      r_rej    <= 1'b0;
      r_err    <= 1'b0;
      r_ready  <= 1'b0;
      r_busy   <= 1'b1;
    end else begin
      r_kick <= 1'b0;
      r_rej  <= 1'b0;
      r_err  <= r_rej;
      case (r_state)
        POR: begin
          if (r_cnt == '0) r_state <= RELEASE;
          else             r_cnt   <= r_cnt - ONE;
        end
        IDLE: begin
          r_busy <= 1'b0;
          if (w_accept) begin
            case (w_op)
              TOGGLE: begin
                if (cmd_mask == '0) begin
                  r_rej <= 1'b1;
                end else begin
                  r_idle   <= w_new_idle;
                  r_active <= w_new_active;
                  r_mask   <= cmd_mask;
                  r_cnt    <= w_new_idle;
                  r_state  <= WAIT_IDLE;
                  r_ready  <= 1'b0;
                end
              end
              ASSERT: begin
                if (cmd_mask == '0) begin
                  r_rej <= 1'b1;
                end else begin
                  r_mask  <= cmd_mask;
                  r_state <= HELD;
                end
              end
              CONFIGURE: begin
                r_idle   <= w_new_idle;
                r_active <= w_new_active;
              end
              default: r_rej <= 1'b1;
            endcase
          end
        end
        WAIT_IDLE: begin
          r_busy <= 1'b1;
          if (r_cnt == '0) begin
            r_cnt   <= w_act_m1;
            r_state <= ACTIVE;
          end else begin
            r_cnt <= r_cnt - ONE;
          end
        end
        ACTIVE: begin
          if (r_cnt == '0) r_state <= RELEASE;
          else             r_cnt   <= r_cnt - ONE;
        end
        HELD: begin
          r_busy <= 1'b1;
          if (w_accept) begin
            if (w_op == DEASSERT) begin
              r_state <= RELEASE;
              r_kick  <= 1'b1;
              r_ready <= 1'b0;
            end else begin
              r_rej <= 1'b1;
            end
          end
        end
        RELEASE: begin
          if (!r_kick && w_rel_done) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= POR;
      endcase
    end
  end

  // Registered channel outputs and edge events, all updated on one edge.
  always_ff @(posedge clock) begin
    r_act     <= w_act_next;
    r_rst_out <= ~(w_act_next ^ RESET_POLARITY);
    if (reset) begin
      r_evt_a <= '0;
      r_evt_d <= '0;
    end else begin
      r_evt_a <= w_act_next & ~r_act;
      r_evt_d <= ~w_act_next & r_act;
    end
  end

  assign cmd_ready    = r_ready;
  assign cmd_err      = r_err;
  assign busy         = r_busy;
  assign rst_active   = r_act;
  assign rst_out      = r_rst_out;
  assign evt_assert   = r_evt_a;
  assign evt_deassert = r_evt_d;

endmodule
